// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file with trap/mret sequencing and a
// one-cycle fetch redirect pulse.
// Optional feature: define CSR_MCYCLE_EN to build the free-running mcycle
// counter; without it mcycle reads 0 and writes to it are dropped.
module csr_regfile #(
  parameter logic [1:0] RESET_MODE = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ra,
  output logic [63:0] rd,
  input  logic        wvalid,
  input  logic [11:0] wa,
  input  logic [63:0] wd,
  input  logic        trap_valid,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_tval,
  input  logic        mret_valid,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  mode
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state;
  logic [63:0] csr_mie;
  logic [63:0] csr_mip;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mtval;
  logic        st_mie;
  logic        st_mpie;
  logic [1:0]  st_mpp;
  logic [63:0] mstatus;
  logic [63:0] mcycle_rd;

  // A CSR write only lands when no trap/mret outranks it and we are not flushing
  logic        csr_we;
  assign csr_we  = (state == IDLE) && !trap_valid && !mret_valid && wvalid;
  assign mstatus = {51'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle;

  // Free-running cycle counter; an accepted write replaces the increment
  always_ff @(posedge clk) begin
    if (reset)
      mcycle <= '0;
    else if (csr_we && wa == A_MCYCLE)
      mcycle <= wd;
    else
      mcycle <= mcycle + 64'd1;
  end

  assign mcycle_rd = mcycle;
`else
  assign mcycle_rd = '0;
`endif

  // Read mux straight from registered state; satp and unmapped read 0
  always_comb begin
    rd = '0;
    case (ra)
      A_MHARTID:  rd = '0;
      A_MIE:      rd = csr_mie;
      A_MIP:      rd = csr_mip;
      A_MTVEC:    rd = mtvec;
      A_MSTATUS:  rd = mstatus;
      A_MSCRATCH: rd = mscratch;
      A_MEPC:     rd = mepc;
      A_MCAUSE:   rd = mcause;
      A_MCYCLE:   rd = mcycle_rd;
      A_MTVAL:    rd = mtval;
      default:    rd = '0;
    endcase
  end

  // Redirect FSM plus CSR updates: trap > mret > write, all ignored in REDIRECT
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mode           <= RESET_MODE;
      csr_mie        <= '0;
      csr_mip        <= '0;
      mtvec          <= '0;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      st_mpp         <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          redirect_valid <= 1'b0;
          if (trap_valid) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= mtvec;
            mepc           <= {trap_pc[63:2], 2'b00};
            mcause         <= trap_cause;
            mtval          <= trap_tval;
            st_mpie        <= st_mie;
            st_mie         <= 1'b0;
            st_mpp         <= mode;
            mode           <= 2'b11;
          end else if (mret_valid) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            st_mie         <= st_mpie;
            st_mpie        <= 1'b1;
            mode           <= st_mpp;
            st_mpp         <= 2'b00;
          end else if (wvalid) begin
            case (wa)
              A_MIE:      csr_mie  <= wd;
              A_MIP:      csr_mip  <= wd;
              A_MTVEC:    mtvec    <= {wd[63:2], 2'b00};
              A_MSCRATCH: mscratch <= wd;
              A_MEPC:     mepc     <= {wd[63:2], 2'b00};
              A_MCAUSE:   mcause   <= wd;
              A_MTVAL:    mtval    <= wd;
              A_MSTATUS: begin
                st_mie  <= wd[3];
                st_mpie <= wd[7];
                st_mpp  <= wd[12:11];
              end
              default: ;
            endcase
          end
        end
        REDIRECT: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter RESET_MODE, default 2'b11, which is the privilege mode loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ra, input, 12 bits: CSR read address.
REQ-005 SHALL have port rd, output, 64 bits: CSR read data.
REQ-006 SHALL have port wvalid, input, 1 bit: CSR write request.
REQ-007 SHALL have port wa, input, 12 bits: CSR write address.
REQ-008 SHALL have port wd, input, 64 bits: CSR write data.
REQ-009 SHALL have port trap_valid, input, 1 bit: the commit stage is taking a trap.
REQ-010 SHALL have ports trap_pc, trap_cause and trap_tval, each an input of 64 bits: the faulting pc, the cause and the tval value.
REQ-011 SHALL have port mret_valid, input, 1 bit: the commit stage is retiring an mret instruction.
REQ-012 SHALL have port redirect_valid, output, 1 bit: a fetch redirect pulse.
REQ-013 SHALL have port redirect_pc, output, 64 bits: the redirect target.
REQ-014 SHALL have port mode, output, 2 bits: the current privilege mode.

Function
REQ-015 SHALL drive rd combinationally from registered state for the addresses mhartid, mie, mip, mtvec, mstatus, mscratch, mepc, mcause, mcycle and mtval, with no write bypass; satp and every unmapped address SHALL read 0.
REQ-016 SHALL apply a write at the clock edge when wvalid is high; writes to mhartid, satp and unmapped addresses SHALL be ignored.
REQ-017 SHALL make only the mstatus fields mie (bit 3), mpie (bit 7) and mpp (bits 12:11) writable; all other mstatus bits SHALL read 0.
REQ-018 SHALL clear bits 1:0 when mtvec or mepc is written (direct mode only).
REQ-019 SHALL increment mcycle by 1 every cycle, wrapping from 2^64-1 to 0; a CSR write to mcycle SHALL win that cycle, loading wd with no increment.
REQ-020 SHALL, on trap_valid, perform all of the following at one edge: mepc<=trap_pc with bits 1:0 cleared, mcause<=trap_cause, mtval<=trap_tval, mpie<=mie, mie<=0, mpp<=mode, mode<=3.
REQ-021 SHALL, on mret_valid, perform all of the following at one edge: mie<=mpie, mpie<=1, mode<=mpp, mpp<=0.
REQ-022 SHALL implement a two-state FSM, IDLE and REDIRECT: from IDLE, an accepted trap or mret SHALL move to REDIRECT; REDIRECT SHALL always return to IDLE on the next edge.
REQ-023 SHALL hold redirect_valid high only in REDIRECT, exactly one cycle after the trap or mret edge; redirect_pc SHALL be the registered target, which is the post-update mtvec for a trap or the mepc at the mret edge for an mret.
REQ-024 SHALL apply the priority trap > mret > CSR write when these are requested in the same cycle; the losing requests SHALL be dropped entirely, except that the mcycle increment continues.
REQ-025 SHALL ignore trap_valid, mret_valid and wvalid while in REDIRECT, since the pipeline is being flushed that cycle.

Reset
REQ-026 SHALL, on reset, load every CSR with 0, set mode to RESET_MODE, set the FSM to IDLE, and drive redirect_valid=0 and redirect_pc=0.
REQ-027 SHALL give reset priority over all other requests; a reset asserted during REDIRECT SHALL drop the redirect pulse in the next cycle.

Configuration
REQ-028 SHALL, when macro CSR_MCYCLE_EN is defined, implement mcycle as described in REQ-019.
REQ-029 SHALL, when CSR_MCYCLE_EN is undefined, read mcycle as 0, ignore writes to it and remove the counter logic.

Verification
REQ-030 SHALL cover: reset, then write mtvec=0x8000_0007 -> mtvec reads 0x8000_0004 next cycle; mhartid reads 0; satp reads 0.
REQ-031 SHALL cover: with mstatus.mie=1 and mode=3, a trap with pc=0x8000_0010 and cause=2 -> the next cycle shows redirect_valid=1, redirect_pc=mtvec, mepc=0x8000_0010, mcause=2, mie=0, mpie=1 and mpp=3; the following cycle shows redirect_valid=0.
REQ-032 SHALL cover: an mret after that trap -> redirect_pc=0x8000_0010, mie=1, mpie=1, mode=3 and mpp=0.
REQ-033 SHALL cover: trap_valid and wvalid (mscratch=5) in the same cycle -> the trap is taken and mscratch is unchanged; trap and mret in the same cycle -> the trap is taken.
REQ-034 SHALL cover: with CSR_MCYCLE_EN defined, write mcycle=0xFFFF_FFFF_FFFF_FFFF -> it reads 0 one cycle later and 1 after that; with the macro undefined, mcycle always reads 0.
REQ-035 SHALL cover: trap_valid asserted during the REDIRECT cycle -> ignored, with no second pulse and mepc unchanged.
